// File: rtl/onehot_mux_sync.sv
// AND-OR one-hot lane multiplexer with optional output register and a
// select-integrity monitor (multi-hot detect plus a sticky error flag).
module onehot_mux_sync #(
  parameter int N_INPUTS = 2,
  parameter int W_INPUT  = 32,
  parameter int REG_OUT  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_INPUTS*W_INPUT-1:0]   in_i,
  input  logic [N_INPUTS-1:0]           sel_i,
  output logic [W_INPUT-1:0]            out_o,
  output logic                          sel_multi_o,
  output logic                          err_sticky_o,
  input  logic                          err_clr_i
);

  logic [W_INPUT-1:0] lane_masked [N_INPUTS];
  logic [W_INPUT-1:0] mux_c;
  logic               seen_one;
  logic               multi_c;
  logic               err_sticky_q;
  logic               err_sticky_d;

  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_lane
      assign lane_masked[gi] = {W_INPUT{sel_i[gi]}} & in_i[gi*W_INPUT +: W_INPUT];
    end
  endgenerate

  // Plain OR of masked lanes: multi-hot selects merge rather than prioritise.
  always_comb begin
    mux_c = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      mux_c = mux_c | lane_masked[i];
    end
  end

  always_comb begin
    seen_one = 1'b0;
    multi_c  = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (sel_i[i]) begin
        if (seen_one) begin
          multi_c = 1'b1;
        end
        seen_one = 1'b1;
      end
    end
  end

  assign sel_multi_o = multi_c;

  // Clear has priority over a simultaneous new error.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (err_clr_i) begin
      err_sticky_d = 1'b0;
    end else if (multi_c) begin
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky_o = err_sticky_q;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [W_INPUT-1:0] out_q;
      logic [W_INPUT-1:0] out_d;

      assign out_d = mux_c;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= '0;
        end else begin
          out_q <= out_d;
        end
      end

      assign out_o = out_q;
    end else begin : g_comb_out
      assign out_o = mux_c;
    end
  endgenerate

endmodule

// File: tb/tb_onehot_mux_sync.sv
// Bench for onehot_mux_sync: four instances covering combinational, registered,
// randomized (scoreboarded) and single-lane configurations.
module tb_onehot_mux_sync;

  logic clk;
  logic rst_n;

  // Instance A: N=2, W=32, combinational
  logic [63:0] in_a;
  logic [1:0]  sel_a;
  logic [31:0] out_a;
  logic        multi_a, sticky_a, clr_a;

  // Instance B: N=4, W=8, registered
  logic [31:0] in_b;
  logic [3:0]  sel_b;
  logic [7:0]  out_b;
  logic        multi_b, sticky_b, clr_b;

  // Instance C: N=5, W=17, registered, randomized
  logic [84:0] in_c;
  logic [4:0]  sel_c;
  logic [16:0] out_c;
  logic        multi_c, sticky_c, clr_c;

  // Instance D: N=1, W=8, combinational
  logic [7:0]  in_d;
  logic [0:0]  sel_d;
  logic [7:0]  out_d;
  logic        multi_d, sticky_d, clr_d;

  int errors = 0;
  int checks = 0;

  onehot_mux_sync #(.N_INPUTS(2), .W_INPUT(32), .REG_OUT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_i(in_a), .sel_i(sel_a), .out_o(out_a),
    .sel_multi_o(multi_a), .err_sticky_o(sticky_a), .err_clr_i(clr_a)
  );

  onehot_mux_sync #(.N_INPUTS(4), .W_INPUT(8), .REG_OUT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_i(in_b), .sel_i(sel_b), .out_o(out_b),
    .sel_multi_o(multi_b), .err_sticky_o(sticky_b), .err_clr_i(clr_b)
  );

  onehot_mux_sync #(.N_INPUTS(5), .W_INPUT(17), .REG_OUT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_i(in_c), .sel_i(sel_c), .out_o(out_c),
    .sel_multi_o(multi_c), .err_sticky_o(sticky_c), .err_clr_i(clr_c)
  );

  onehot_mux_sync #(.N_INPUTS(1), .W_INPUT(8), .REG_OUT(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_i(in_d), .sel_i(sel_d), .out_o(out_d),
    .sel_multi_o(multi_d), .err_sticky_o(sticky_d), .err_clr_i(clr_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [16:0] ref_c(input logic [84:0] v, input logic [4:0] s);
    logic [16:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      if (s[i]) r = v[i*17 +: 17];
    end
    return r;
  endfunction

  typedef struct {
    logic [1:0]  sel;
    logic        clr;
    logic [31:0] out;
    logic        multi;
    logic        sticky;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic       multi;
  } mvec_t;

  vec_t        vecs [10];
  mvec_t       mvecs[5];
  logic [16:0] sb_q [$];

  initial begin
    logic [95:0] rnd;
    logic [16:0] exp_c;
    int          k;

    vecs[0] = '{2'b01, 1'b0, 32'hAAAA0001, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 1'b0, 32'hBBBB0002, 1'b0, 1'b0};
    vecs[2] = '{2'b00, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 1'b0, 32'hBBBB0003, 1'b1, 1'b1};
    vecs[4] = '{2'b11, 1'b1, 32'hBBBB0003, 1'b1, 1'b0};
    vecs[5] = '{2'b01, 1'b0, 32'hAAAA0001, 1'b0, 1'b0};
    vecs[6] = '{2'b11, 1'b0, 32'hBBBB0003, 1'b1, 1'b1};
    vecs[7] = '{2'b00, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vecs[8] = '{2'b10, 1'b1, 32'hBBBB0002, 1'b0, 1'b0};
    vecs[9] = '{2'b10, 1'b0, 32'hBBBB0002, 1'b0, 1'b0};

    mvecs[0] = '{4'b1000, 1'b0};
    mvecs[1] = '{4'b1001, 1'b1};
    mvecs[2] = '{4'b1111, 1'b1};
    mvecs[3] = '{4'b0000, 1'b0};
    mvecs[4] = '{4'b0110, 1'b1};

    rst_n = 1'b0;
    in_a = {32'hBBBB0002, 32'hAAAA0001}; sel_a = '0; clr_a = 1'b0;
    in_b = '0; sel_b = '0; clr_b = 1'b0;
    in_c = '0; sel_c = '0; clr_c = 1'b0;
    in_d = '0; sel_d = '0; clr_d = 1'b0;

    #1;
    check("reset out_b", out_b, 8'h00);
    check("reset out_c", out_c, 17'h0);
    check("reset sticky_a", sticky_a, 1'b0);
    check("reset sticky_b", sticky_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sequence on the combinational instance
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sel_a = vecs[i].sel;
      clr_a = vecs[i].clr;
      #1;
      check($sformatf("A[%0d] out", i), out_a, vecs[i].out);
      check($sformatf("A[%0d] sel_multi", i), multi_a, vecs[i].multi);
      @(posedge clk);
      #1;
      check($sformatf("A[%0d] err_sticky", i), sticky_a, vecs[i].sticky);
    end
    clr_a = 1'b0;

    // Registered instance: one-cycle latency
    @(negedge clk);
    in_b  = {8'hC3, 8'h5A, 8'h3C, 8'h11};
    sel_b = 4'b0100;
    #1;
    check("B out before edge", out_b, 8'h00);
    @(posedge clk);
    #1;
    check("B out after edge", out_b, 8'h5A);
    check("B sticky clean", sticky_b, 1'b0);
    @(negedge clk);
    sel_b = 4'b0110;
    #1;
    check("B multi immediate", multi_b, 1'b1);
    check("B out still held", out_b, 8'h5A);
    @(posedge clk);
    #1;
    check("B out or-merge", out_b, 8'h7E);
    check("B sticky set", sticky_b, 1'b1);

    // Asynchronous reset between edges
    #1;
    rst_n = 1'b0;
    sel_a = 2'b10;
    #1;
    check("B out async reset", out_b, 8'h00);
    check("B sticky async reset", sticky_b, 1'b0);
    check("A out tracks in reset", out_a, 32'hBBBB0002);
    @(negedge clk);
    rst_n = 1'b1;
    sel_b = 4'b0000;
    @(posedge clk);
    #1;
    check("B out sel zero", out_b, 8'h00);

    // Popcount threshold on a 4-lane select
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sel_b = mvecs[i].sel;
      #1;
      check($sformatf("B multi sel=%b", mvecs[i].sel), multi_b, mvecs[i].multi);
    end
    sel_b = '0;

    // Single-lane instance
    @(negedge clk);
    in_d = 8'h96; sel_d = 1'b1;
    #1;
    check("D out sel1", out_d, 8'h96);
    check("D multi", multi_d, 1'b0);
    sel_d = 1'b0;
    #1;
    check("D out sel0", out_d, 8'h00);

    // Randomized one-hot/zero run, scoreboarded against the registered output
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      rnd  = {$urandom, $urandom, $urandom};
      in_c = rnd[84:0];
      k    = int'($urandom_range(0, 5));
      sel_c = (k == 5) ? 5'b0 : 5'(1 << k);
      sb_q.push_back(ref_c(in_c, sel_c));
      #1;
      checks++;
      if (multi_c !== 1'b0) begin
        errors++;
        $display("FAIL C[%0d] sel_multi: got %b expected 0 (sel=%b)", n, multi_c, sel_c);
      end
      @(posedge clk);
      #1;
      exp_c = sb_q.pop_front();
      checks++;
      if (out_c !== exp_c) begin
        errors++;
        $display("FAIL C[%0d] out: got %h expected %h (sel=%b)", n, out_c, exp_c, sel_c);
      end
    end
    check("C scoreboard drained", 64'(sb_q.size()), 64'd0);
    check("C sticky never set", sticky_c, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
